// File: rtl/mont_sq_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// mont_sq_sequencer_pkg
// Shared types and constants for the Montgomery squaring sequencer.
//   state_e     : sequencer states (one issue/capture pair per multiplier pass)
//   CTL_*       : one-hot multiplier mode codes driven on o_mul_ctl
// ---------------------------------------------------------------------------
package mont_sq_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SQ_ISS = 3'd1,
    ST_SQ_CAP = 3'd2,
    ST_ML_ISS = 3'd3,
    ST_ML_CAP = 3'd4,
    ST_MH_ISS = 3'd5,
    ST_MH_CAP = 3'd6,
    ST_DONE   = 3'd7
  } state_e;

  localparam logic [2:0] CTL_NONE   = 3'b000;
  localparam logic [2:0] CTL_SQ     = 3'b001;  // full square X*X
  localparam logic [2:0] CTL_MUL_LO = 3'b010;  // low half of L*M'
  localparam logic [2:0] CTL_MUL_HI = 3'b100;  // high half of Q*M + H

endpackage

// File: rtl/mont_sq_sequencer.sv
// ---------------------------------------------------------------------------
// mont_sq_sequencer
// Drives an external (registered, 1-cycle latency) multiplier through
// i_iter Montgomery squarings X <- X^2 * R^-1 (mod M, redundant form).
// Each squaring is three multiplier passes: square, low multiply by -M^-1,
// high multiply by M with H added, each as an issue cycle followed by a
// capture cycle (6 cycles per squaring).
//
// Ports
//   i_clk, i_rst          : clock, asynchronous active-high reset
//   i_valid / o_ready     : job request handshake (o_ready only in IDLE)
//   i_x, i_iter           : initial value, number of squarings
//   i_mod, i_mod_inv      : modulus M and -M^-1 mod R, latched on accept
//   o_valid / i_ready     : result handshake, o_x held until consumed
//   o_x                   : result X
//   o_mul_ctl             : one-hot multiplier mode (000 when not issuing)
//   o_mul_a/_b/_add       : multiplier operands (zero when not issuing)
//   i_mul_dat             : multiplier product, 2*NUM_ELEMENTS words
// All outputs are registered.
// ---------------------------------------------------------------------------
module mont_sq_sequencer
  import mont_sq_sequencer_pkg::*;
#(
  parameter int NUM_ELEMENTS = 33,
  parameter int DSP_BIT_LEN  = 17,
  parameter int WORD_LEN     = 16,
  parameter int ITER_W       = 32
) (
  input  logic                                       i_clk,
  input  logic                                       i_rst,
  input  logic                                       i_valid,
  output logic                                       o_ready,
  input  logic [NUM_ELEMENTS-1:0][DSP_BIT_LEN-1:0]   i_x,
  input  logic [ITER_W-1:0]                          i_iter,
  input  logic [NUM_ELEMENTS-1:0][DSP_BIT_LEN-1:0]   i_mod,
  input  logic [NUM_ELEMENTS-1:0][DSP_BIT_LEN-1:0]   i_mod_inv,
  output logic                                       o_valid,
  input  logic                                       i_ready,
  output logic [NUM_ELEMENTS-1:0][DSP_BIT_LEN-1:0]   o_x,
  output logic [2:0]                                 o_mul_ctl,
  output logic [NUM_ELEMENTS-1:0][DSP_BIT_LEN-1:0]   o_mul_a,
  output logic [NUM_ELEMENTS-1:0][DSP_BIT_LEN-1:0]   o_mul_b,
  output logic [NUM_ELEMENTS-1:0][DSP_BIT_LEN-1:0]   o_mul_add,
  input  logic [2*NUM_ELEMENTS-1:0][DSP_BIT_LEN-1:0] i_mul_dat
);

  // A redundant word is WORD_LEN radix bits plus carry headroom.
  localparam int CARRY_W = DSP_BIT_LEN - WORD_LEN;
  typedef logic [NUM_ELEMENTS-1:0][CARRY_W+WORD_LEN-1:0] vec_t;

  localparam logic [ITER_W-1:0] CNT_ZERO = {ITER_W{1'b0}};
  localparam logic [ITER_W-1:0] CNT_ONE  = {{(ITER_W-1){1'b0}}, 1'b1};

  state_e            state_q, state_d;
  logic [ITER_W-1:0] cnt_q, cnt_d;
  vec_t              x_q, x_d;
  vec_t              l_q, l_d;
  vec_t              h_q, h_d;
  vec_t              q_q, q_d;
  vec_t              mod_q, mod_d;
  vec_t              minv_q, minv_d;

  logic              ready_q, ready_d;
  logic              valid_q, valid_d;
  logic [2:0]        ctl_q, ctl_d;
  vec_t              a_q, a_d;
  vec_t              b_q, b_d;
  vec_t              add_q, add_d;

  vec_t              prod_lo;
  vec_t              prod_hi;

  assign prod_lo = i_mul_dat[NUM_ELEMENTS-1:0];
  assign prod_hi = i_mul_dat[2*NUM_ELEMENTS-1:NUM_ELEMENTS];

  // Next-state, datapath captures and next values of the registered outputs.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    x_d     = x_q;
    l_d     = l_q;
    h_d     = h_q;
    q_d     = q_q;
    mod_d   = mod_q;
    minv_d  = minv_q;

    case (state_q)
      ST_IDLE: begin
        if (i_valid) begin
          x_d    = i_x;
          mod_d  = i_mod;
          minv_d = i_mod_inv;
          cnt_d  = i_iter;
          state_d = (i_iter == CNT_ZERO) ? ST_DONE : ST_SQ_ISS;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SQ_ISS: state_d = ST_SQ_CAP;
      ST_SQ_CAP: begin
        l_d     = prod_lo;
        h_d     = prod_hi;
        state_d = ST_ML_ISS;
      end
      ST_ML_ISS: state_d = ST_ML_CAP;
      ST_ML_CAP: begin
        q_d     = prod_lo;
        state_d = ST_MH_ISS;
      end
      ST_MH_ISS: state_d = ST_MH_CAP;
      ST_MH_CAP: begin
        x_d   = prod_hi;
        // Only reached with cnt_q >= 1, so the decrement never wraps.
        cnt_d = cnt_q - CNT_ONE;
        state_d = (cnt_d != CNT_ZERO) ? ST_SQ_ISS : ST_DONE;
      end
      ST_DONE: begin
        if (i_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Outputs are decoded from the next state so they appear registered
    // in the same cycle the state register enters that state.
    ready_d = (state_d == ST_IDLE);
    valid_d = (state_d == ST_DONE);
    ctl_d   = CTL_NONE;
    a_d     = '0;
    b_d     = '0;
    add_d   = '0;
    case (state_d)
      ST_SQ_ISS: begin
        ctl_d = CTL_SQ;
        a_d   = x_d;
        b_d   = x_d;
      end
      ST_ML_ISS: begin
        ctl_d = CTL_MUL_LO;
        a_d   = l_d;
        b_d   = minv_d;
      end
      ST_MH_ISS: begin
        ctl_d = CTL_MUL_HI;
        a_d   = q_d;
        b_d   = mod_d;
        add_d = h_d;
      end
      default: begin
        ctl_d = CTL_NONE;
      end
    endcase
  end

  // State, datapath and output registers with asynchronous reset.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= CNT_ZERO;
      x_q     <= '0;
      l_q     <= '0;
      h_q     <= '0;
      q_q     <= '0;
      mod_q   <= '0;
      minv_q  <= '0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
      ctl_q   <= CTL_NONE;
      a_q     <= '0;
      b_q     <= '0;
      add_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      l_q     <= l_d;
      h_q     <= h_d;
      q_q     <= q_d;
      mod_q   <= mod_d;
      minv_q  <= minv_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
      ctl_q   <= ctl_d;
      a_q     <= a_d;
      b_q     <= b_d;
      add_q   <= add_d;
    end
  end

  assign o_ready   = ready_q;
  assign o_valid   = valid_q;
  assign o_x       = x_q;
  assign o_mul_ctl = ctl_q;
  assign o_mul_a   = a_q;
  assign o_mul_b   = b_q;
  assign o_mul_add = add_q;

endmodule

// File: tb/tb_mont_sq_sequencer.sv
// ---------------------------------------------------------------------------
// tb_mont_sq_sequencer
// Self-checking bench: a behavioural multiplier answers the sequencer, and
// results are checked with big-integer modular arithmetic:
//   X_n * R^(2^n - 1) == x^(2^n)  (mod M)
// ---------------------------------------------------------------------------
module tb_mont_sq_sequencer;
  import mont_sq_sequencer_pkg::*;

  localparam int NE = 33;
  localparam int DW = 17;
  localparam int WL = 16;
  localparam int IW = 32;
  localparam int RB = NE * WL;  // R = 2^RB

  typedef logic [NE-1:0][DW-1:0]   vec_t;
  typedef logic [2*NE-1:0][DW-1:0] dvec_t;
  typedef logic [1087:0]           big_t;
  typedef logic [RB-1:0]           rword_t;

  localparam big_t ONE   = big_t'(1'b1);
  localparam big_t R_VAL = ONE << RB;

  logic          clk = 1'b0;
  logic          rst;
  logic          valid_in;
  logic          ready_out;
  vec_t          x_in;
  logic [IW-1:0] iter_in;
  vec_t          mod_in;
  vec_t          minv_in;
  logic          valid_out;
  logic          ready_in;
  vec_t          x_out;
  logic [2:0]    mul_ctl;
  vec_t          mul_a;
  vec_t          mul_b;
  vec_t          mul_add;
  dvec_t         mul_dat = '0;

  int n_assert = 0;
  int n_fail   = 0;

  mont_sq_sequencer #(
    .NUM_ELEMENTS(NE), .DSP_BIT_LEN(DW), .WORD_LEN(WL), .ITER_W(IW)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_valid(valid_in), .o_ready(ready_out),
    .i_x(x_in), .i_iter(iter_in), .i_mod(mod_in), .i_mod_inv(minv_in),
    .o_valid(valid_out), .i_ready(ready_in), .o_x(x_out),
    .o_mul_ctl(mul_ctl), .o_mul_a(mul_a), .o_mul_b(mul_b),
    .o_mul_add(mul_add), .i_mul_dat(mul_dat)
  );

  always #5 clk = ~clk;

  function automatic big_t to_int(input vec_t v);
    big_t r = '0;
    for (int i = NE - 1; i >= 0; i--) r = (r << WL) + big_t'(v[i]);
    return r;
  endfunction

  function automatic vec_t to_vec(input big_t v);
    vec_t r;
    for (int i = 0; i < NE; i++) r[i] = {1'b0, v[WL*i +: WL]};
    return r;
  endfunction

  function automatic dvec_t to_dvec(input big_t v);
    dvec_t r;
    for (int i = 0; i < 2 * NE; i++) r[i] = {1'b0, v[WL*i +: WL]};
    return r;
  endfunction

  // Companion multiplier: one-cycle registered product. The high pass adds
  // H one radix-R position up and rounds the low half up, so its high half
  // is exactly (X^2 + Q*M) / R.
  always @(posedge clk) begin
    case (mul_ctl)
      CTL_SQ, CTL_MUL_LO: mul_dat <= to_dvec(to_int(mul_a) * to_int(mul_b));
      CTL_MUL_HI: mul_dat <= to_dvec(to_int(mul_a) * to_int(mul_b)
                                     + (to_int(mul_add) << RB) + R_VAL - ONE);
      default: mul_dat <= '0;
    endcase
  end

  // -M^-1 mod R by Newton iteration (odd M: M is its own inverse mod 8).
  function automatic rword_t neg_inv(input rword_t m);
    rword_t inv = m;
    for (int k = 0; k < 10; k++) inv = inv * ({{(RB-2){1'b0}}, 2'b10} - m * inv);
    return -inv;
  endfunction

  function automatic big_t modmul(input big_t a, input big_t b, input big_t m);
    return (a * b) % m;
  endfunction

  // Odd modulus with M < R/4.
  function automatic rword_t rand_mod();
    rword_t m;
    for (int i = 0; i < NE - 1; i++) m[WL*i +: WL] = 16'($urandom());
    m[WL*(NE-1) +: WL] = 16'h1000 + 16'($urandom_range(0, 32'h2FFF));
    m[0] = 1'b1;
    return m;
  endfunction

  // Value below every modulus rand_mod can return.
  function automatic big_t rand_x();
    big_t x = '0;
    for (int i = 0; i < NE - 1; i++) x[WL*i +: WL] = 16'($urandom());
    x[WL*(NE-1) +: WL] = 16'($urandom_range(0, 32'h0FFF));
    return x;
  endfunction

  function automatic logic [2:0] ctl_at(input int idx);
    case (idx)
      0:       return CTL_SQ;
      2:       return CTL_MUL_LO;
      4:       return CTL_MUL_HI;
      default: return CTL_NONE;
    endcase
  endfunction

  task automatic chk(input string tag, input big_t obs, input big_t exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_equiv(input string tag, input big_t x0, input int iter,
                             input vec_t ox, input rword_t m);
    big_t mb = big_t'(m);
    big_t expv = x0 % mb;
    big_t rm = R_VAL % mb;
    big_t rp = ONE;
    big_t got;
    for (int k = 0; k < iter; k++) expv = modmul(expv, expv, mb);
    for (int k = 0; k < (1 << iter) - 1; k++) rp = modmul(rp, rm, mb);
    got = modmul(to_int(ox) % mb, rp, mb);
    chk({tag, "_modM"}, got, expv);
  endtask

  // Accept a job, check every cycle until o_valid, optionally stall the
  // result for `stall` cycles while pulsing i_valid, then consume it.
  task automatic run_job(input string tag, input big_t x, input logic [IW-1:0] iter,
                         input rword_t m, input int stall);
    int   lat = 6 * int'(iter) + 1;
    vec_t res;
    x_in     = to_vec(x);
    iter_in  = iter;
    mod_in   = to_vec(big_t'(m));
    minv_in  = to_vec(big_t'(neg_inv(m)));
    valid_in = 1'b1;
    ready_in = 1'b0;
    chk({tag, "_ready_idle"}, big_t'(ready_out), ONE);
    @(negedge clk);
    valid_in = 1'b0;
    for (int n = 1; n < lat; n++) begin
      int idx = (n - 1) % 6;
      chk($sformatf("%s_ctl_c%0d", tag, n), big_t'(mul_ctl), big_t'(ctl_at(idx)));
      chk($sformatf("%s_busy_c%0d", tag, n), big_t'({valid_out, ready_out}), big_t'(2'b00));
      if (idx % 2 == 1) begin
        chk($sformatf("%s_ops0_c%0d", tag, n), big_t'(mul_a | mul_b | mul_add), '0);
      end else if (idx == 0 && n == 1) begin
        chk({tag, "_sq_a"}, big_t'(mul_a), big_t'(to_vec(x)));
        chk({tag, "_sq_b"}, big_t'(mul_b), big_t'(to_vec(x)));
      end else if (idx == 2) begin
        chk($sformatf("%s_ml_b_c%0d", tag, n), big_t'(mul_b), big_t'(to_vec(big_t'(neg_inv(m)))));
      end else if (idx == 4) begin
        chk($sformatf("%s_mh_b_c%0d", tag, n), big_t'(mul_b), big_t'(to_vec(big_t'(m))));
      end else begin
        chk($sformatf("%s_add0_c%0d", tag, n), big_t'(mul_add), '0);
      end
      @(negedge clk);
    end
    chk({tag, "_valid_at_lat"}, big_t'(valid_out), ONE);
    chk({tag, "_ctl_done"}, big_t'(mul_ctl), big_t'(CTL_NONE));
    res = x_out;
    if (iter == '0) chk({tag, "_x_passthru"}, big_t'(x_out), big_t'(to_vec(x)));
    else check_equiv(tag, x, int'(iter), x_out, m);
    for (int s = 0; s < stall; s++) begin
      valid_in = (s % 2 == 0);
      x_in = to_vec(rand_x());
      @(negedge clk);
      chk($sformatf("%s_hold_v%0d", tag, s), big_t'({valid_out, ready_out}), big_t'(2'b10));
      chk($sformatf("%s_hold_x%0d", tag, s), big_t'(x_out), big_t'(res));
    end
    valid_in = 1'b0;
    ready_in = 1'b1;
    @(negedge clk);
    ready_in = 1'b0;
    chk({tag, "_idle_after"}, big_t'({valid_out, ready_out}), big_t'(2'b01));
  endtask

  initial begin
    rword_t m;
    int     found;
    int     seen_valid;
    rst = 1'b1; valid_in = 1'b0; ready_in = 1'b0;
    x_in = '0; iter_in = '0; mod_in = '0; minv_in = '0;
    repeat (2) @(negedge clk);
    chk("rst_ready", big_t'(ready_out), ONE);
    chk("rst_valid", big_t'(valid_out), '0);
    chk("rst_ctl", big_t'(mul_ctl), '0);
    chk("rst_x", big_t'(x_out), '0);
    chk("rst_ops", big_t'(mul_a | mul_b | mul_add), '0);
    rst = 1'b0;
    @(negedge clk);

    m = rand_mod();
    run_job("it0", rand_x(), 32'd0, m, 0);
    run_job("it1", rand_x(), 32'd1, m, 0);
    m = rand_mod();
    run_job("it5", rand_x(), 32'd5, m, 0);
    for (int j = 0; j < 3; j++) begin
      m = rand_mod();
      run_job($sformatf("rnd%0d", j), rand_x(), 32'($urandom_range(1, 4)), m, 0);
    end
    run_job("stall", rand_x(), 32'd2, m, 10);

    // Reset while the iter=3 job sits in ML_CAP.
    m = rand_mod();
    x_in = to_vec(rand_x()); iter_in = 32'd3;
    mod_in = to_vec(big_t'(m)); minv_in = to_vec(big_t'(neg_inv(m)));
    valid_in = 1'b1;
    @(negedge clk);
    valid_in = 1'b0;
    found = 0;
    for (int k = 0; k < 12 && found == 0; k++) begin
      if (mul_ctl == CTL_MUL_LO) found = 1;
      else @(negedge clk);
    end
    chk("rst_find_ml_iss", big_t'(found), ONE);
    @(negedge clk);
    chk("rst_ml_cap_ctl", big_t'(mul_ctl), big_t'(CTL_NONE));
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_idle", big_t'({valid_out, ready_out}), big_t'(2'b01));
    chk("midrst_ctl", big_t'(mul_ctl), big_t'(CTL_NONE));
    chk("midrst_x", big_t'(x_out), '0);
    rst = 1'b0;
    seen_valid = 0;
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      if (valid_out) seen_valid++;
    end
    chk("midrst_no_valid", big_t'(seen_valid), '0);
    run_job("post_rst", rand_x(), 32'd2, m, 0);

    // Maximum iteration count: must keep squaring, never finish early.
    x_in = to_vec(rand_x()); iter_in = '1;
    valid_in = 1'b1;
    @(negedge clk);
    valid_in = 1'b0;
    seen_valid = 0;
    for (int n = 1; n <= 60; n++) begin
      chk($sformatf("maxit_ctl_c%0d", n), big_t'(mul_ctl), big_t'(ctl_at((n - 1) % 6)));
      if (valid_out) seen_valid++;
      @(negedge clk);
    end
    chk("maxit_no_valid", big_t'(seen_valid), '0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("maxit_rst_idle", big_t'({valid_out, ready_out}), big_t'(2'b01));
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "time limit exceeded");
  end

endmodule
